fetch_queue: RTL
================

# fetch_queue

Instruction fetch queue that sits between the program counter and the decode stage. It accepts one fetch address per handshake from the PC side and issues a single 120-bit read to instruction memory. It splits the returned bundle into two 60-bit instructions, tags each with its bit address, and buffers them for decode. It discards queued and in-flight instructions on a flush, which is driven on jump or branch redirect.

## Interface
Parameters:
- ADDR_W, 72, width of fetch address (bit-addressed, matches pc).
- INST_W, 60, instruction width; bundle is 2*INST_W = 120 bits.
- DEPTH, 8, queue capacity in instructions; power of 2, ≥ 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_valid  in  1  fetch address available.
- pc  in  ADDR_W  fetch address (start of 120-bit bundle).
- pc_ready  out  1  request accepted this cycle when pc_valid & pc_ready.
- flush  in  1  redirect; drop queue and any in-flight bundle.
- mem_req  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  read address, valid while mem_req.
- mem_rvalid  in  1  read data valid, one cycle per request.
- mem_rdata  in  2*INST_W  bundle; [INST_W-1:0] is the first instruction.
- inst_valid  out  1  queue head valid.
- inst  out  INST_W  head instruction.
- inst_addr  out  ADDR_W  head instruction bit address.
- inst_ready  in  1  decode consumes head when inst_valid & inst_ready.

## Operation
- FSM states:
  - IDLE: no read outstanding.
  - WAIT: read outstanding, data to be kept.
  - DISCARD: read outstanding, data to be dropped.
- pc_ready = (state==IDLE) & (free ≥ 2) & !flush, where free = DEPTH − count. The 2-entry space is reserved at acceptance, so a push never overflows.
- IDLE, accept: latch pc into req_addr, go to WAIT.
- WAIT, mem_rvalid & !flush:
  - push mem_rdata[INST_W-1:0] with address req_addr;
  - push mem_rdata[2*INST_W-1:INST_W] with address req_addr+INST_W;
  - go to IDLE.
- WAIT, flush & !mem_rvalid: go to DISCARD.
- WAIT, flush & mem_rvalid: drop the data, go to IDLE.
- DISCARD, mem_rvalid: drop the data, go to IDLE. Flush in DISCARD has no further effect.
- mem_rvalid in IDLE is ignored.
- Flush has priority over pop and push in the same cycle: count becomes 0, and the read/write pointers reset to 0.
- Count update per cycle: +2 on push, −1 on pop, net +1 when both occur.
- Pop is allowed only when count ≠ 0. inst_ready with inst_valid=0 is ignored.
- Address arithmetic is modulo 2^ADDR_W; req_addr+INST_W wraps silently.
- Reset values:
  - state IDLE; count, pointers and req_addr 0;
  - mem_req 0, mem_addr 0, inst_valid 0, inst 0, inst_addr 0;
  - pc_ready 0 while reset is asserted.

## Timing
- mem_req is registered: it is high for exactly one cycle, the cycle after acceptance, with mem_addr = accepted pc. mem_addr holds its value until the next request.
- Memory latency is ≥ 1 cycle after mem_req; mem_rvalid in the same cycle as mem_req is a protocol violation.
- At most one read is outstanding; pc_ready is low from the acceptance edge until the cycle after mem_rvalid.
- The queue write is registered: the pushed instructions are visible one cycle after mem_rvalid. In an empty queue, inst_valid rises the cycle after mem_rvalid.
- Head output is a direct read of storage at the read pointer. inst and inst_addr are stable while inst_valid & !inst_ready.
- Flush takes effect at the next edge: inst_valid is 0 the cycle after flush. pc_ready is combinationally low during flush.
- Best-case fetch rate is one bundle per 3 cycles at 1-cycle memory latency.
- Asserting reset mid-operation returns all state to reset values immediately. A mem_rvalid arriving after reset deasserts lands in IDLE and is ignored.

## Structure
- Package fetch_pkg:
  - INST_W, BUNDLE_W (=120), ADDR_W;
  - FSM state enum {IDLE, WAIT, DISCARD}.
- Sub-module fetch_fifo: DEPTH-entry storage of {inst, inst_addr}, 2-wide push, 1-wide pop, synchronous clear, count output.
- fetch_queue contains the FSM, request register and address tagging.

## Test plan
- Reset then pc=0, 1-cycle memory returning bundle {B,A}:
  - mem_req with mem_addr=0 the cycle after acceptance;
  - inst A/addr 0, then B/addr 60;
  - inst_valid rises the cycle after mem_rvalid.
- Backpressure: inst_ready=0, issue fetches at 0, 120, 240, 360 with DEPTH=8:
  - the 4th is accepted (count 6→8 after it lands);
  - the 5th is held with pc_ready=0 until two pops free space.
- Flush in WAIT with 3-cycle latency:
  - inst_valid=0 next cycle;
  - the returning bundle is dropped (no push, count stays 0);
  - pc_ready returns the cycle after mem_rvalid.
- Flush coincident with mem_rvalid and with a pop: count=0, no push, state IDLE next cycle.
- Wrap-around: pc = 2^72 − 60. The second instruction's address is 0.
- Reset asserted while in WAIT with a queue count of 5:
  - outputs are 0 immediately;
  - a late mem_rvalid after reset is ignored, count stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths and FSM state encoding for the instruction fetch queue.
package fetch_pkg;
  localparam int ADDR_W   = 72;
  localparam int INST_W   = 60;
  localparam int BUNDLE_W = 2 * INST_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries, two entries written per push, one read per pop.
module fetch_fifo #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 132
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         push_lo,
  input  logic [ENTRY_W-1:0]         push_hi,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_pop;

  // A pop against an empty buffer is dropped rather than corrupting rd_ptr.
  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]               <= push_lo;
        mem[wr_ptr + PTR_W'(1)]   <= push_hi;
        wr_ptr                    <= wr_ptr + PTR_W'(2);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(2);
        2'b01:   count <= count - CNT_W'(1);
        2'b11:   count <= count + CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: one outstanding 120-bit bundle read, split into two tagged
// instructions and buffered for decode; flush drops queued and in-flight data.
module fetch_queue #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int INST_W = fetch_pkg::INST_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pc_valid,
  input  logic [ADDR_W-1:0]        pc,
  output logic                     pc_ready,
  input  logic                     flush,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_rvalid,
  input  logic [2*INST_W-1:0]      mem_rdata,
  output logic                     inst_valid,
  output logic [INST_W-1:0]        inst,
  output logic [ADDR_W-1:0]        inst_addr,
  input  logic                     inst_ready,
  output fetch_pkg::fetch_state_t  state_dbg,
  output logic [$clog2(DEPTH):0]   count_dbg
);
  import fetch_pkg::*;

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INST_W + ADDR_W;

  fetch_state_t        state;
  logic [ADDR_W-1:0]   req_addr;
  logic [CNT_W-1:0]    count;
  logic [ENTRY_W-1:0]  head;
  logic                accept;
  logic                push;
  logic                pop;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and ready may depend combinationally on flush.
  assign pc_ready = !reset && (state == IDLE) && (count <= CNT_W'(DEPTH - 2)) && !flush;
  assign accept   = pc_valid && pc_ready;
  assign push     = (state == WAIT) && mem_rvalid && !flush;
  assign pop      = inst_valid && inst_ready;

  assign inst_valid = (count != '0);
  assign inst       = head[ENTRY_W-1:ADDR_W];
  assign inst_addr  = head[ADDR_W-1:0];
  assign state_dbg  = state;
  assign count_dbg  = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_addr <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_req <= accept;
      if (accept) begin
        req_addr <= pc;
        mem_addr <= pc;
      end
      case (state)
        IDLE:    if (accept) state <= WAIT;
        WAIT: begin
          if (mem_rvalid)  state <= IDLE;
          else if (flush)  state <= DISCARD;
        end
        DISCARD: if (mem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Second instruction's tag wraps modulo 2^ADDR_W.
  fetch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .push    (push),
    .push_lo ({mem_rdata[INST_W-1:0], req_addr}),
    .push_hi ({mem_rdata[2*INST_W-1:INST_W], req_addr + ADDR_W'(INST_W)}),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );
endmodule
